// File: rtl/oscillator_pkg.sv
// Shared types and default constants for the collision-tone oscillator.
package oscillator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GOOD = 2'd1,
    BAD  = 2'd2
  } osc_state_t;

  localparam int DEFAULT_CNT_W       = 8;
  localparam int DEFAULT_GOOD_PERIOD = 16;
  localparam int DEFAULT_BAD_PERIOD  = 40;
  localparam int DEFAULT_TONE_CYCLES = 400;

  // Bits needed to hold a countdown starting at the tone duration.
  function automatic int timer_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/tone_counter.sv
// Period counter: wraps after period-1 and flags the terminal count.
module tone_counter #(
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic           clear,
  input  logic [CNT_W:0] period,
  output logic           at_max
);

  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   last_full;
  logic [CNT_W-1:0] last;
  logic             hit;

  // period may equal 2^CNT_W, so the subtraction is done one bit wider.
  assign last_full = period - (CNT_W + 1)'(1);
  assign last      = last_full[CNT_W-1:0];
  assign hit       = (count == last);
  assign at_max    = enable && hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= hit ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/oscillator.sv
// Collision-tone oscillator: a request starts or retriggers a timed tone
// whose pitch is set by the at_max pulse spacing.
module oscillator
  import oscillator_pkg::*;
#(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int GOOD_PERIOD = DEFAULT_GOOD_PERIOD,
  parameter int BAD_PERIOD  = DEFAULT_BAD_PERIOD,
  parameter int TONE_CYCLES = DEFAULT_TONE_CYCLES
) (
  input  logic clk,
  input  logic nRst,
  input  logic goodColl,
  input  logic badColl,
  output logic at_max
);

  localparam int TIMER_W = timer_width(TONE_CYCLES);
  localparam logic [TIMER_W-1:0] TONE_LOAD = TIMER_W'(TONE_CYCLES);
  localparam logic [CNT_W:0]     GOOD_LEN  = (CNT_W + 1)'(GOOD_PERIOD);
  localparam logic [CNT_W:0]     BAD_LEN   = (CNT_W + 1)'(BAD_PERIOD);

  osc_state_t       state;
  osc_state_t       next_state;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_next;
  logic             request;
  logic             enable;
  logic             clear;
  logic [CNT_W:0]   period;

  assign request = goodColl | badColl;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= next_state;
      timer <= timer_next;
    end
  end

  // Bad requests win ties; the tone ends on the edge the timer reaches zero.
  always_comb begin
    next_state = state;
    timer_next = timer;
    if (badColl) begin
      next_state = BAD;
      timer_next = TONE_LOAD;
    end else if (goodColl) begin
      next_state = GOOD;
      timer_next = TONE_LOAD;
    end else if (state != IDLE) begin
      if (timer <= TIMER_W'(1)) begin
        next_state = IDLE;
        timer_next = '0;
      end else begin
        timer_next = timer - TIMER_W'(1);
      end
    end
  end

  // The counter restarts only when the tone changes or the tone ends.
  always_comb begin
    enable = (state != IDLE);
    period = (state == BAD) ? BAD_LEN : GOOD_LEN;
    clear  = (next_state == IDLE) || (request && (next_state != state));
  end

  tone_counter #(
    .CNT_W(CNT_W)
  ) u_tone_counter (
    .clk   (clk),
    .rst_n (nRst),
    .enable(enable),
    .clear (clear),
    .period(period),
    .at_max(at_max)
  );

endmodule

// File: tb/tb_oscillator.sv
// Self-checking bench for oscillator: directed scenarios plus random
// requests, compared against an edge-numbered tone model.
module tb_oscillator;

  localparam int CNT_W       = 8;
  localparam int GOOD_PERIOD = 16;
  localparam int BAD_PERIOD  = 40;
  localparam int TONE_CYCLES = 400;

  logic clk;
  logic nRst;
  logic goodColl;
  logic badColl;
  logic at_max;

  int assertCount = 0;
  int failCount   = 0;
  int pulseCount  = 0;

  // Model: a tone is described by the edge it started on, its pitch and
  // the edge of the most recent request.
  int edgeNum     = 0;
  int startEdge   = 0;
  int lastReq     = 0;
  bit toneBad     = 0;
  bit modelActive = 0;

  oscillator #(
    .CNT_W      (CNT_W),
    .GOOD_PERIOD(GOOD_PERIOD),
    .BAD_PERIOD (BAD_PERIOD),
    .TONE_CYCLES(TONE_CYCLES)
  ) dut (
    .clk     (clk),
    .nRst    (nRst),
    .goodColl(goodColl),
    .badColl (badColl),
    .at_max  (at_max)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #(2_000_000 * 10);
    $display("[TB] FAIL watchdog: simulation time limit reached, observed running required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at edge %0d: observed %0d required %0d", tag, edgeNum, observed, expected);
    end
  endtask

  task automatic updateModel(input bit g, input bit b);
    edgeNum++;
    if (g || b) begin
      if (!modelActive || (b != toneBad)) begin
        startEdge = edgeNum;
        toneBad   = b;
      end
      lastReq     = edgeNum;
      modelActive = 1;
    end else if (modelActive && (edgeNum - lastReq >= TONE_CYCLES)) begin
      modelActive = 0;
    end
  endtask

  function automatic int expectedAtMax();
    int p;
    p = toneBad ? BAD_PERIOD : GOOD_PERIOD;
    if (!modelActive) return 0;
    return (((edgeNum - startEdge) % p) == (p - 1)) ? 1 : 0;
  endfunction

  // Called on a falling edge: drive inputs, let one rising edge pass, check.
  task automatic applyStimulus(input string tag, input bit g, input bit b);
    goodColl = g;
    badColl  = b;
    @(posedge clk);
    if (nRst) updateModel(g, b);
    else begin
      edgeNum++;
      modelActive = 0;
    end
    @(negedge clk);
    if (at_max === 1'b1) pulseCount++;
    checkOutput(tag, int'(at_max), expectedAtMax());
  endtask

  task automatic idleCycles(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 1'b0);
  endtask

  task automatic assertReset(input string tag);
    nRst = 1'b0;
    modelActive = 0;
    #1;
    checkOutput(tag, int'(at_max), 0);
  endtask

  task automatic releaseReset(input string tag);
    @(negedge clk);
    goodColl = 1'b0;
    badColl  = 1'b0;
    nRst     = 1'b1;
    #1;
    checkOutput(tag, int'(at_max), 0);
  endtask

  initial begin
    nRst     = 1'b0;
    goodColl = 1'b1;
    badColl  = 1'b0;
    #1;
    checkOutput("reset_initial", int'(at_max), 0);
    @(negedge clk);

    applyStimulus("reset_hold_good", 1'b1, 1'b0);
    applyStimulus("reset_hold_good", 1'b1, 1'b0);
    applyStimulus("reset_hold", 1'b0, 1'b0);
    applyStimulus("reset_hold", 1'b0, 1'b0);
    releaseReset("reset_release");
    idleCycles("idle_after_reset", 10);

    pulseCount = 0;
    for (int i = 0; i < 5; i++) applyStimulus("good_tone", 1'b1, 1'b0);
    idleCycles("good_tone", 420);
    checkOutput("good_pulse_count", pulseCount, 25);

    pulseCount = 0;
    for (int i = 0; i < 5; i++) applyStimulus("bad_tone", 1'b0, 1'b1);
    idleCycles("bad_tone", 420);
    checkOutput("bad_pulse_count", pulseCount, 10);

    pulseCount = 0;
    applyStimulus("both_tone", 1'b1, 1'b1);
    idleCycles("both_tone", 420);
    checkOutput("both_pulse_count", pulseCount, 10);

    pulseCount = 0;
    applyStimulus("switch_tone", 1'b1, 1'b0);
    idleCycles("switch_tone", 99);
    applyStimulus("switch_tone", 1'b0, 1'b1);
    idleCycles("switch_tone", 420);
    checkOutput("switch_pulse_count", pulseCount, 16);

    applyStimulus("mid_reset_tone", 1'b1, 1'b0);
    idleCycles("mid_reset_tone", 47);
    checkOutput("mid_reset_pulse_before", int'(at_max), 1);
    #2;
    assertReset("mid_reset_async");
    applyStimulus("mid_reset_hold", 1'b0, 1'b0);
    applyStimulus("mid_reset_hold", 1'b0, 1'b0);
    releaseReset("mid_reset_release");
    pulseCount = 0;
    idleCycles("after_mid_reset", 100);
    checkOutput("after_mid_reset_pulses", pulseCount, 0);

    for (int seg = 0; seg < 30; seg++) begin
      int reqLen;
      int idleLen;
      reqLen  = $urandom_range(1, 6);
      idleLen = $urandom_range(0, 500);
      for (int r = 0; r < reqLen; r++) begin
        bit g;
        bit b;
        g = 1'($urandom_range(0, 1));
        b = ($urandom_range(0, 3) == 0);
        applyStimulus("random_req", g, b);
      end
      if ($urandom_range(0, 4) == 0) begin
        idleCycles("random_idle", idleLen / 2);
        #2;
        assertReset("random_async_reset");
        for (int h = 0; h < $urandom_range(1, 2); h++) applyStimulus("random_reset_hold", 1'b1, 1'b0);
        releaseReset("random_reset_release");
        idleCycles("random_idle", idleLen / 2);
      end else begin
        idleCycles("random_idle", idleLen);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/oscillator.md
OSCILLATOR -- requirements
Module: oscillator

Interface
- REQ-001 SHALL have parameter CNT_W, default 8: width of the period counter.
- REQ-002 SHALL have parameter GOOD_PERIOD, default 16: clock cycles per at_max pulse during the good-collision tone (2..2^CNT_W).
- REQ-003 SHALL have parameter BAD_PERIOD, default 40: clock cycles per at_max pulse during the bad-collision tone (2..2^CNT_W).
- REQ-004 SHALL have parameter TONE_CYCLES, default 400: tone duration, counted from the last cycle a collision input was sampled high.
- REQ-005 clk  input  1  system clock; all state changes on its rising edge.
- REQ-006 nRst  input  1  reset, asynchronous, active-low.
- REQ-007 goodColl  input  1  level request for the good-collision (high-pitch) tone.
- REQ-008 badColl  input  1  level request for the bad-collision (low-pitch) tone.
- REQ-009 at_max  output  1  one-cycle pulse each time the period counter reaches its terminal value; this pulse train is the audio square-wave toggle.

Function
- REQ-010 SHALL implement states IDLE, GOOD and BAD.
- REQ-011 IDLE: counter held at 0, timer held at 0, at_max = 0.
- REQ-012 SHALL give badColl priority when both inputs are sampled high in the same cycle, and select BAD.
- REQ-013 SHALL, on a sampled request, enter or stay in the requested state and load the timer with TONE_CYCLES.
- REQ-014 SHALL reset the counter to 0 only on a tone change (IDLE->GOOD/BAD or GOOD<->BAD); a same-tone re-request SHALL reload the timer only.
- REQ-015 In GOOD/BAD with no request, the timer SHALL decrement by 1 per cycle; the state SHALL return to IDLE on the edge where the timer becomes 0, and the counter SHALL clear.
- REQ-016 In GOOD/BAD, the counter SHALL increment by 1 per cycle and wrap to 0 after reaching PERIOD-1, where PERIOD is GOOD_PERIOD or BAD_PERIOD.
- REQ-017 at_max SHALL be combinational: 1 exactly when the state is not IDLE and the counter equals PERIOD-1; otherwise 0.
- REQ-018 First pulse after a request sampled at edge k from IDLE: at_max SHALL be high in the cycle after edge k+PERIOD-1.
- REQ-019 Counter and timer SHALL never overflow; the comparison widths SHALL match CNT_W and ceil(log2(TONE_CYCLES+1)).

Reset
- REQ-020 nRst low SHALL immediately force state IDLE, counter 0, timer 0 and at_max 0, independent of clk.
- REQ-021 SHALL hold these values while nRst is low, including while collision inputs are high and across clock edges.
- REQ-022 SHALL resume sampling inputs on the first rising edge after nRst is released; reset asserted mid-tone SHALL abort the tone.

Structure
- REQ-023 The state enum (IDLE, GOOD, BAD) and the default period and duration constants SHALL reside in the shared package oscillator_pkg.
- REQ-024 The period counter with wrap and terminal-count detect SHALL be the sub-module tone_counter (inputs: enable, clear, period; output: at_max).

Verification
- REQ-025 Reset: nRst=0 for 2 cycles, with and without goodColl=1 -> at_max=0 throughout, including immediately after release.
- REQ-026 Good tone: goodColl=1 for 5 cycles from edge k -> first at_max pulse after edge k+15, then every 16 cycles; IDLE after edge k+404; exactly 25 pulses.
- REQ-027 Bad tone: badColl=1 for 5 cycles -> pulses every 40 cycles; exactly 10 pulses; then at_max stays 0.
- REQ-028 Simultaneous goodColl=badColl=1 for 1 cycle -> 40-cycle spacing (BAD).
- REQ-029 Switch: badColl pulse at cycle 100 of a good tone -> counter restarts; next pulse 40 cycles later; tone ends 400 cycles after the bad request.
- REQ-030 Reset mid-tone: nRst low at cycle 50 of a good tone -> at_max=0 immediately and stays 0 after release with no request.
